// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, 1-cycle program-memory reads, fetch queue toward decode.
// Optional FETCH_PERF_EN adds fetch/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_flush_count
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   instr_q [QUEUE_DEPTH];
  logic [31:0]   pc_q    [QUEUE_DEPTH];

  logic          pop;
  logic          push;
  logic [OW-1:0] occupancy;
  logic [31:0]   branch_addr;
  logic [1:0]    unused_branch_lsb;

  assign unused_branch_lsb = pc_branch[1:0];

  // Occupancy counts the in-flight response so it always finds a free slot.
  always_comb begin
    branch_addr = {pc_branch[31:2], 2'b00};
    valid       = !rst && (count != '0) && !branch_taken;
    pop         = valid && !stall;
    push        = inflight && !branch_taken;
    occupancy   = OW'(count) + OW'(inflight) - OW'(pop);
    imem_req    = !rst && (branch_taken || (occupancy < OW'(QUEUE_DEPTH)));
    imem_addr   = branch_taken ? branch_addr : fetch_pc;
    instruction = valid ? instr_q[head] : NOP;
    pc          = valid ? pc_q[head] : 32'h0000_0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'h0000_0000;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (branch_taken) begin
      fetch_pc    <= branch_addr + 32'd4;
      inflight_pc <= branch_addr;
      inflight    <= 1'b1;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

  // Queue payload needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_q[tail] <= imem_rdata;
      pc_q[tail]    <= inflight_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_count <= 32'h0000_0000;
      perf_flush_count <= 32'h0000_0000;
    end else begin
      if (pop)          perf_fetch_count <= perf_fetch_count + 32'd1;
      if (branch_taken) perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule
